// File: rtl/frac_divider.sv
// Sequential radix-2 restoring divider producing dividend/divisor as an unsigned
// Q0.FRAC_WIDTH fraction, with a pass-through tag and saturation/zero flags.
module frac_divider #(
    parameter int IN_WIDTH   = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int TAG_WIDTH  = 4,
    parameter int ROUND      = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_dividend,
    input  logic [IN_WIDTH-1:0]   in_divisor,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FRAC_WIDTH-1:0] out_quotient,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_saturated,
    output logic                  out_div_by_zero
);

    // One extra quotient bit is developed when rounding so the half-LSB is known.
    localparam int QW = FRAC_WIDTH + ROUND;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH:0]     rem_q, rem_d;
    logic [IN_WIDTH-1:0]   divisor_q, divisor_d;
    logic [QW-1:0]         quot_q, quot_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [FRAC_WIDTH-1:0] res_q, res_d;
    logic                  sat_q, sat_d;
    logic                  dbz_q, dbz_d;

    logic [IN_WIDTH:0]     r2;
    logic                  qbit;
    logic [QW-1:0]         quot_next;

    // Returns {saturated, quotient}; round half up may carry out of the field.
    function automatic logic [FRAC_WIDTH:0] finish_quot(input logic [QW-1:0] q);
        logic [FRAC_WIDTH:0] sum;
        if (ROUND == 0) begin
            return {1'b0, FRAC_WIDTH'(q)};
        end
        sum = (FRAC_WIDTH+1)'(q >> 1) + (FRAC_WIDTH+1)'(q[0]);
        if (sum[FRAC_WIDTH]) begin
            return {1'b1, {FRAC_WIDTH{1'b1}}};
        end
        return sum;
    endfunction

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        quot_d    = quot_q;
        cnt_d     = cnt_q;
        tag_d     = tag_q;
        res_d     = res_q;
        sat_d     = sat_q;
        dbz_d     = dbz_q;

        r2        = rem_q << 1;
        qbit      = (r2 >= {1'b0, divisor_q});
        quot_next = QW'({quot_q, qbit});

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    divisor_d = in_divisor;
                    tag_d     = in_tag;
                    if (in_divisor == '0) begin
                        state_d = DONE;
                        res_d   = '1;
                        sat_d   = 1'b1;
                        dbz_d   = 1'b1;
                    end else if (in_dividend >= in_divisor) begin
                        state_d = DONE;
                        res_d   = '1;
                        sat_d   = 1'b1;
                        dbz_d   = 1'b0;
                    end else begin
                        rem_d   = {1'b0, in_dividend};
                        quot_d  = '0;
                        cnt_d   = CW'(QW);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d  = qbit ? (r2 - {1'b0, divisor_q}) : r2;
                quot_d = quot_next;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d        = DONE;
                    {sat_d, res_d} = finish_quot(quot_next);
                    dbz_d          = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            tag_q     <= '0;
            res_q     <= '0;
            sat_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            quot_q    <= quot_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            res_q     <= res_d;
            sat_q     <= sat_d;
            dbz_q     <= dbz_d;
        end
    end

    assign in_ready        = (state_q == IDLE);
    assign out_valid       = (state_q == DONE);
    assign out_quotient    = res_q;
    assign out_tag         = tag_q;
    assign out_saturated   = sat_q;
    assign out_div_by_zero = dbz_q;

endmodule
